seg_scan: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 25 ++
 rtl/seg_hex_decode.sv | 34 +++
 rtl/seg_scan.sv | 111 +++++++++++
 tb/tb_seg_scan.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scanner: glyph table, blank pattern, digit count.
// Patterns are active-high in {dp, g, f, e, d, c, b, a} order.
package seg_scan_pkg;

  localparam int unsigned NumDigits = 3;
  localparam logic [7:0]  SegBlank  = 8'h00;

  localparam logic [7:0] SegHex0 = 8'h3F;
  localparam logic [7:0] SegHex1 = 8'h06;
  localparam logic [7:0] SegHex2 = 8'h5B;
  localparam logic [7:0] SegHex3 = 8'h4F;
  localparam logic [7:0] SegHex4 = 8'h66;
  localparam logic [7:0] SegHex5 = 8'h6D;
  localparam logic [7:0] SegHex6 = 8'h7D;
  localparam logic [7:0] SegHex7 = 8'h07;
  localparam logic [7:0] SegHex8 = 8'h7F;
  localparam logic [7:0] SegHex9 = 8'h6F;
  localparam logic [7:0] SegHexA = 8'h77;
  localparam logic [7:0] SegHexB = 8'h7C;
  localparam logic [7:0] SegHexC = 8'h39;
  localparam logic [7:0] SegHexD = 8'h5E;
  localparam logic [7:0] SegHexE = 8'h79;
  localparam logic [7:0] SegHexF = 8'h71;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-digit to active-high segment pattern, with forced blanking.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] pattern_o
);

  always_comb begin
    pattern_o = SegBlank;
    if (!blank_i) begin
      unique case (digit_i)
        4'h0: pattern_o = SegHex0;
        4'h1: pattern_o = SegHex1;
        4'h2: pattern_o = SegHex2;
        4'h3: pattern_o = SegHex3;
        4'h4: pattern_o = SegHex4;
        4'h5: pattern_o = SegHex5;
        4'h6: pattern_o = SegHex6;
        4'h7: pattern_o = SegHex7;
        4'h8: pattern_o = SegHex8;
        4'h9: pattern_o = SegHex9;
        4'hA: pattern_o = SegHexA;
        4'hB: pattern_o = SegHexB;
        4'hC: pattern_o = SegHexC;
        4'hD: pattern_o = SegHexD;
        4'hE: pattern_o = SegHexE;
        default: pattern_o = SegHexF;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed three-digit hex scanner with ghost blanking, leading-zero blanking
// and a per-frame snapshot of the displayed value.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned TICK_CNT   = 50000,
  parameter int unsigned GHOST      = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] smg_in,
  input  logic        blank_en,
  output logic [2:0]  seg_sel,
  output logic [7:0]  seg_out,
  output logic        frame_done
);

  localparam int unsigned CntW     = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(TICK_CNT - 1);
  localparam logic [CntW-1:0] GhostCnt = CntW'(GHOST);
  localparam logic [1:0] IdxLast = 2'(NumDigits - 1);
  localparam logic [NumDigits-1:0] SelMask = ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0] OutMask = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [11:0]          shadow_q, shadow_d;
  logic [NumDigits-1:0] seg_sel_q, seg_sel_d;
  logic [7:0]           seg_out_q, seg_out_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick, wrap, load, blank;
  logic [3:0]           digit;
  logic [7:0]           pattern;

  assign tick = (cnt_q == CntMax);
  assign wrap = tick && (idx_q == IdxLast);
  // Reload at slot start, and once more on the first edge of a slot so a freshly reset
  // display picks up its first digit without waiting a whole slot.
  assign load = tick || (cnt_q == '0);

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = wrap;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? 2'd0 : idx_q + 2'd1;
    end
    if (wrap) begin
      shadow_d = smg_in;
    end
  end

  always_comb begin
    digit = shadow_d[3:0];
    blank = 1'b0;
    unique case (idx_d)
      2'd1: begin
        digit = shadow_d[7:4];
        blank = blank_en && (shadow_d[11:4] == 8'h00);
      end
      2'd2: begin
        digit = shadow_d[11:8];
        blank = blank_en && (shadow_d[11:8] == 4'h0);
      end
      default: begin
        digit = shadow_d[3:0];
        blank = 1'b0;
      end
    endcase
  end

  seg_hex_decode u_dec (
    .digit_i   (digit),
    .blank_i   (blank),
    .pattern_o (pattern)
  );

  always_comb begin
    seg_sel_d = SelMask;
    if (cnt_d >= GhostCnt) begin
      seg_sel_d = SelMask ^ (NumDigits'(1) << idx_d);
    end
    seg_out_d = load ? (OutMask ^ pattern) : seg_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 12'h000;
      seg_sel_q    <= SelMask;
      seg_out_q    <= OutMask ^ SegBlank;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_sel_q    <= seg_sel_d;
      seg_out_q    <= seg_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_sel    = seg_sel_q;
  assign seg_out    = seg_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a frame-level reference model predicts each lit slot and
// each frame_done pulse; a negedge monitor checks both polarity variants against it.
module tb_seg_scan;

  localparam int unsigned TICK  = 8;
  localparam int unsigned GH    = 2;
  localparam int unsigned FRAME = 3 * TICK;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] smg_in = 12'h000;
  logic        blank_en = 1'b0;
  logic [2:0]  sel_l, sel_h;
  logic [7:0]  out_l, out_h;
  logic        fd_l, fd_h;

  always #5 clk = ~clk;

  seg_scan #(.TICK_CNT(TICK), .GHOST(GH), .ACTIVE_LOW(1'b1)) u_dut_low (
    .clk        (clk),
    .reset      (reset),
    .smg_in     (smg_in),
    .blank_en   (blank_en),
    .seg_sel    (sel_l),
    .seg_out    (out_l),
    .frame_done (fd_l)
  );

  seg_scan #(.TICK_CNT(TICK), .GHOST(GH), .ACTIVE_LOW(1'b0)) u_dut_high (
    .clk        (clk),
    .reset      (reset),
    .smg_in     (smg_in),
    .blank_en   (blank_en),
    .seg_sel    (sel_h),
    .seg_out    (out_h),
    .frame_done (fd_h)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: standard glyphs written out directly, active-high.
  logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [7:0] exp_pattern(input logic [11:0] v, input int idx,
                                             input logic blk);
    logic [3:0] d;
    d = v[idx*4 +: 4];
    if (blk && idx == 2 && v[11:8] == 4'h0) return 8'h00;
    if (blk && idx == 1 && v[11:4] == 8'h00) return 8'h00;
    return glyph_tab[d];
  endfunction

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] out;
  } slot_t;

  slot_t       slot_q[$];
  int          fd_q[$];
  int          m_k = 0;
  logic [11:0] m_shadow = 12'h000;

  // m_k counts clock edges since the last reset edge; everything else is arithmetic on it.
  always @(posedge clk) begin
    int          k;
    int          idx;
    logic [11:0] sh;
    slot_t       s;
    k  = reset ? 0 : m_k + 1;
    sh = m_shadow;
    if (reset) begin
      sh = 12'h000;
    end else begin
      if (k % FRAME == 0) begin
        sh = smg_in;
        fd_q.push_back(k);
      end
      if (k % TICK == GH) begin
        idx   = (k / TICK) % 3;
        s.sel = 3'(1 << idx);
        s.out = exp_pattern(sh, idx, blank_en);
        slot_q.push_back(s);
      end
    end
    m_k      <= k;
    m_shadow <= sh;
  end

  int   mon_k = 0;
  logic rst_edge = 1'b1;

  always @(posedge clk) begin
    rst_edge <= reset;
    mon_k    <= reset ? 0 : mon_k + 1;
  end

  int         ghost_run = 0;
  int         act_run = 0;
  logic [7:0] slot_out_l = 8'h00;
  logic [2:0] slot_sel_l = 3'b000;

  always @(negedge clk) begin
    slot_t      s;
    logic       exp_fd;
    logic [2:0] es;
    logic [7:0] eo;
    exp_fd = (fd_q.size() > 0) && (fd_q[0] == mon_k);
    if (fd_l || fd_h || exp_fd) begin
      check("frame_done_low", {31'b0, fd_l}, {31'b0, exp_fd});
      check("frame_done_high", {31'b0, fd_h}, {31'b0, exp_fd});
      if (exp_fd) void'(fd_q.pop_front());
    end
    if (rst_edge) begin
      ghost_run = 1;
      act_run   = 0;
    end else if (sel_l == 3'b111) begin
      if (act_run > 0) begin
        check("active_len", act_run, TICK - GH);
        act_run = 0;
      end
      ghost_run++;
    end else begin
      if (act_run == 0) begin
        check("ghost_len", ghost_run, GH);
        ghost_run = 0;
        if (slot_q.size() == 0) begin
          check("slot_unexpected", {29'b0, sel_l}, 32'h7);
        end else begin
          s  = slot_q.pop_front();
          es = ~s.sel;
          eo = ~s.out;
          check("sel_low", {29'b0, sel_l}, {29'b0, es});
          check("out_low", {24'b0, out_l}, {24'b0, eo});
          check("sel_high", {29'b0, sel_h}, {29'b0, s.sel});
          check("out_high", {24'b0, out_h}, {24'b0, s.out});
        end
        slot_out_l = out_l;
        slot_sel_l = sel_l;
      end else begin
        check("out_stable", {24'b0, out_l}, {24'b0, slot_out_l});
        check("sel_stable", {29'b0, sel_l}, {29'b0, slot_sel_l});
      end
      act_run++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_low"}, {29'b0, sel_l}, 32'h7);
    check({tag, "_out_low"}, {24'b0, out_l}, 32'hFF);
    check({tag, "_fd_low"}, {31'b0, fd_l}, 32'h0);
    check({tag, "_sel_high"}, {29'b0, sel_h}, 32'h0);
    check({tag, "_out_high"}, {24'b0, out_h}, 32'h0);
    check({tag, "_fd_high"}, {31'b0, fd_h}, 32'h0);
  endtask

  task automatic wait_frame_pos(input int pos, input string tag);
    for (int i = 0; i < 2 * FRAME && (m_k % FRAME) != pos; i++) step(1);
    check(tag, m_k % FRAME, pos);
  endtask

  initial begin
    step(3);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // Mid-slot reset while digit 1 is lit.
    step(12);
    check("pre_reset_sel", {29'b0, sel_l}, 32'h5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_slot_rst");
    @(posedge clk);
    #1 reset = 1'b0;

    smg_in = 12'h3A7;
    step(3 * FRAME + 4);

    smg_in = 12'h111;
    step(2 * FRAME);
    wait_frame_pos(TICK + 3, "snap_align");
    smg_in = 12'h222;
    step(2 * FRAME);

    reset    = 1'b1;
    blank_en = 1'b1;
    smg_in   = 12'h005;
    step(1);
    reset = 1'b0;
    step(2 * FRAME + 4);
    smg_in = 12'h000;
    step(2 * FRAME);
    smg_in = 12'h050;
    step(2 * FRAME);

    // Reset coinciding with the frame-wrap edge: no capture, no pulse.
    reset    = 1'b1;
    blank_en = 1'b0;
    step(1);
    reset  = 1'b0;
    smg_in = 12'h999;
    wait_frame_pos(FRAME - 1, "collide_align");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(FRAME + 4);

    repeat (12) begin
      if ($urandom_range(3) == 0) begin
        reset    = 1'b1;
        blank_en = 1'($urandom);
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
      smg_in = 12'($urandom);
      step($urandom_range(5, 40));
    end

    step(FRAME);
    @(negedge clk);
    #1;
    check("slot_queue_drained", slot_q.size(), 0);
    check("fd_queue_drained", fd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
